// File: rtl/adc_avg_bcd_pkg.sv
// adc_avg_bcd_pkg: shared widths and state encoding for the ADC averaging BCD converter
package adc_avg_bcd_pkg;
  localparam int ADC_W = 12;
  localparam int BCD_DIGITS = 4;
  localparam int DD_W = ADC_W + 4 * BCD_DIGITS;
  typedef enum logic {ACCUM = 1'b0, CONV = 1'b1} state_t;
endpackage

// File: rtl/adc_avg_bcd_dd_step.sv
// adc_avg_bcd_dd_step: one double-dabble iteration, add 3 to every BCD nibble >= 5 then shift left
//   d: {bcd digits, binary remainder} before the step; q: the same bus after the step
module adc_avg_bcd_dd_step
  import adc_avg_bcd_pkg::*;
(
  input  logic [DD_W-1:0] d,
  output logic [DD_W-1:0] q
);
  logic [DD_W-1:0] t;
  always_comb begin
    t = d;
    for (int i = 0; i < BCD_DIGITS; i++)
      t[ADC_W+4*i +: 4] = t[ADC_W+4*i +: 4] >= 4'd5 ? t[ADC_W+4*i +: 4] + 4'd3 : t[ADC_W+4*i +: 4];
    q = t << 1;
  end
endmodule

// File: rtl/adc_avg_bcd.sv
// adc_avg_bcd: averages 2^AVG_LOG2 ADC samples and converts the average to four BCD digits
//   clk, nCR (sync active-low reset); sample_valid/sample: ADC input
//   busy: converting; drop: sample discarded while busy
//   avg_out/bcd_out: held result; bcd_valid: one-cycle pulse when the result updates
module adc_avg_bcd
  import adc_avg_bcd_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic             clk,
  input  logic             nCR,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample,
  output logic             busy,
  output logic             drop,
  output logic [ADC_W-1:0] avg_out,
  output logic [15:0]      bcd_out,
  output logic             bcd_valid
);
  localparam int AW = ADC_W + AVG_LOG2;
  localparam logic [4:0] LAST = 5'((1 << AVG_LOG2) - 1);
  state_t state, state_next;
  logic [AW-1:0] acc, sum;
  logic [4:0] cnt;
  logic [3:0] iter;
  logic [ADC_W-1:0] avg, avg_r;
  logic [DD_W-1:0] dd, dd_next;
  logic accept, last, last_step;
  adc_avg_bcd_dd_step u_step (.d(dd), .q(dd_next));
  assign busy = state == CONV;
  always_comb begin
    accept = sample_valid && state == ACCUM;
    last = accept && cnt == LAST;
    last_step = state == CONV && iter == 4'd11;
    sum = acc + AW'(sample);
    avg = ADC_W'(sum >> AVG_LOG2);
    state_next = last ? CONV : last_step ? ACCUM : state;
  end
  always_ff @(posedge clk) state <= !nCR ? ACCUM : state_next;
  always_ff @(posedge clk) begin
    if (!nCR) begin
      drop <= 1'b0;
      bcd_valid <= 1'b0;
      avg_out <= '0;
      bcd_out <= '0;
      acc <= '0;
      cnt <= '0;
      iter <= '0;
      avg_r <= '0;
      dd <= '0;
    end else begin
      drop <= sample_valid && state == CONV;
      bcd_valid <= last_step;
      if (accept) begin
        acc <= last ? '0 : sum;
        cnt <= last ? '0 : cnt + 5'd1;
      end
      if (last) begin
        avg_r <= avg;
        dd <= {16'h0, avg};
        iter <= '0;
      end else if (state == CONV) begin
        dd <= dd_next;
        iter <= iter + 4'd1;
      end
      if (last_step) begin
        bcd_out <= dd_next[DD_W-1 -: 16];
        avg_out <= avg_r;
      end
    end
  end
endmodule
